// File: rtl/rv_pipe_pkg.sv
// Shared constants and types for the three-stage RISC-V pipeline.
// The IF/EXE register and later stages reuse NOP_INSTR for their own bubbles.
package rv_pipe_pkg;

  localparam int PC_W = 14;

  localparam logic [31:0] NOP_INSTR    = 32'h00000013;
  localparam logic [31:0] EBREAK_INSTR = 32'h00100073;

  typedef enum logic [1:0] {
    FETCH_BOOT = 2'd0,
    FETCH_RUN  = 2'd1,
    FETCH_HALT = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_stage_pc_next_sel.sv
// Next-PC priority mux for the fetch stage: reset, redirect, hold, increment.
// Also flags redirect targets whose low two bits are nonzero.
module pc_next_sel
  import rv_pipe_pkg::*;
#(
  parameter int                  PC_W     = rv_pipe_pkg::PC_W,
  parameter logic [PC_W-1:0]     RESET_PC = '0
) (
  input  logic            rst,
  input  logic            redirect_en,
  input  logic [PC_W-1:0] redirect_pc,
  input  logic            hold,
  input  logic [PC_W-1:0] pc_fetch,
  output logic [PC_W-1:0] pc_next,
  output logic            misaligned
);

  logic [PC_W-1:0] tgt;

  assign tgt        = {redirect_pc[PC_W-1:2], 2'b00};
  assign misaligned = redirect_en & (redirect_pc[1:0] != 2'b00);

  // Increment wraps naturally at the top of the PC_W-bit address space.
  always_comb begin
    pc_next = pc_fetch + PC_W'(4);
    if (rst) begin
      pc_next = RESET_PC;
    end else if (redirect_en) begin
      pc_next = tgt;
    end else if (hold) begin
      pc_next = pc_fetch;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the synchronous IMEM BRAM and
// presents instruction/PC/valid to decode, inserting bubbles where needed.
module fetch_stage
#(
  parameter int              PC_W      = rv_pipe_pkg::PC_W,
  parameter logic [PC_W-1:0] RESET_PC  = '0,
  parameter logic [31:0]     NOP_INSTR = rv_pipe_pkg::NOP_INSTR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            redirect_en,
  input  logic [PC_W-1:0] redirect_pc,
  output logic            imem_en,
  output logic [PC_W-3:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  output logic [31:0]     instruction_out,
  output logic [PC_W-1:0] PC_out,
  output logic            valid_out,
  output logic            halted,
  output logic            misalign_err,
  output logic [31:0]     fetch_count
);

  import rv_pipe_pkg::*;

  localparam logic [1:0] BOOT = FETCH_BOOT;
  localparam logic [1:0] RUN  = FETCH_RUN;
  localparam logic [1:0] HALT = FETCH_HALT;

  logic [1:0]      state;
  logic [PC_W-1:0] pc_fetch;
  logic [PC_W-1:0] pc_next;
  logic            hold;
  logic            issue;
  logic            misaligned;
  logic            is_ebreak;

  assign hold      = (state != RUN) | stall;
  assign issue     = ~rst & (state == RUN) & ~stall & ~redirect_en;
  assign is_ebreak = (imem_rdata == EBREAK_INSTR);

  pc_next_sel #(
    .PC_W     (PC_W),
    .RESET_PC (RESET_PC)
  ) u_pc_next_sel (
    .rst         (rst),
    .redirect_en (redirect_en),
    .redirect_pc (redirect_pc),
    .hold        (hold),
    .pc_fetch    (pc_fetch),
    .pc_next     (pc_next),
    .misaligned  (misaligned)
  );

  // BRAM is addressed with pc_next so its data lines up with pc_fetch next cycle.
  assign imem_en         = ~rst;
  assign imem_addr       = pc_next[PC_W-1:2];
  assign instruction_out = issue ? imem_rdata : NOP_INSTR;
  assign valid_out       = issue;
  assign PC_out          = pc_fetch;
  assign halted          = ~rst & (state == HALT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= BOOT;
      pc_fetch     <= RESET_PC;
      misalign_err <= 1'b0;
      fetch_count  <= '0;
    end else begin
      pc_fetch    <= pc_next;
      fetch_count <= fetch_count + {31'b0, issue};
      if (misaligned) begin
        misalign_err <= 1'b1;
      end
      // BOOT lasts one cycle because the BRAM output is stale after reset.
      case (state)
        BOOT: state <= RUN;
        RUN: begin
          if (issue && is_ebreak) begin
            state <= HALT;
          end
        end
        HALT: begin
          if (redirect_en) begin
            state <= RUN;
          end
        end
        default: state <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, a short
// halt/reset sequence, and randomized traffic against a behavioural model.
module tb_fetch_stage;

  localparam logic [31:0] NOP    = 32'h00000013;
  localparam logic [31:0] EBREAK = 32'h00100073;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect_en;
  logic [13:0] redirect_pc;
  logic        imem_en;
  logic [11:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] instruction_out;
  logic [13:0] PC_out;
  logic        valid_out;
  logic        halted;
  logic        misalign_err;
  logic [31:0] fetch_count;

  int pass_count = 0;
  int check_count = 0;

  logic [31:0] mem [4096];

  fetch_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .redirect_en     (redirect_en),
    .redirect_pc     (redirect_pc),
    .imem_en         (imem_en),
    .imem_addr       (imem_addr),
    .imem_rdata      (imem_rdata),
    .instruction_out (instruction_out),
    .PC_out          (PC_out),
    .valid_out       (valid_out),
    .halted          (halted),
    .misalign_err    (misalign_err),
    .fetch_count     (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous instruction BRAM with one-cycle read latency.
  initial imem_rdata = 32'hDEADBEEF;
  always @(posedge clk) begin
    if (imem_en) imem_rdata <= mem[imem_addr];
  end

  // Behavioural model: mode 0 = booting, 1 = running, 2 = halted.
  int          m_pc = 0;
  int          m_mode = 0;
  int unsigned m_count = 0;
  bit          m_mis = 0;
  bit          m_known = 0;

  typedef struct {
    bit          rst;
    bit          stall;
    bit          red;
    int          rpc;
    int          valid;
    logic [31:0] instr;
    int          pc;
    int          halted;
    int          count;
    int          mis;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(bit r, bit s, bit rd, int rpc, int v, logic [31:0] ins,
                              int pc, int h, int c, int mi);
    vec_t x;
    x.rst = r; x.stall = s; x.red = rd; x.rpc = rpc;
    x.valid = v; x.instr = ins; x.pc = pc; x.halted = h; x.count = c; x.mis = mi;
    return x;
  endfunction

  task automatic check_output(string name, logic [31:0] act, logic [31:0] exp);
    check_count++;
    if (act === exp) pass_count++;
    else $display("[TB] FAIL %s got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic model_check();
    bit          issue;
    int          nxt;
    logic [31:0] e_instr;
    issue   = !rst && m_mode == 1 && !stall && !redirect_en;
    e_instr = issue ? mem[m_pc / 4] : NOP;
    if (rst) nxt = 0;
    else if (redirect_en) nxt = int'(redirect_pc) / 4 * 4;
    else if (m_mode != 1 || stall) nxt = m_pc;
    else nxt = (m_pc + 4) % 16384;

    check_output("mdl_imem_en", {31'b0, imem_en}, {31'b0, !rst});
    check_output("mdl_imem_addr", {20'b0, imem_addr}, 32'(nxt / 4));
    check_output("mdl_valid", {31'b0, valid_out}, {31'b0, issue});
    check_output("mdl_instr", instruction_out, e_instr);
    check_output("mdl_halted", {31'b0, halted}, {31'b0, !rst && m_mode == 2});
    if (m_known) begin
      check_output("mdl_pc", {18'b0, PC_out}, 32'(m_pc));
      check_output("mdl_count", fetch_count, m_count);
      check_output("mdl_mis", {31'b0, misalign_err}, {31'b0, m_mis});
    end

    if (rst) begin
      m_mode = 0; m_count = 0; m_mis = 0; m_known = 1;
    end else begin
      if (redirect_en && redirect_pc[1:0] != 2'b00) m_mis = 1;
      if (issue) m_count++;
      if (redirect_en) m_mode = 1;
      else if (m_mode == 0) m_mode = 1;
      else if (issue && e_instr == EBREAK) m_mode = 2;
    end
    m_pc = nxt;
  endtask

  task automatic apply_stimulus(bit r, bit s, bit rd, logic [13:0] rpc);
    @(negedge clk);
    rst = r; stall = s; redirect_en = rd; redirect_pc = rpc;
    #1;
    model_check();
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; redirect_en = 1'b0; redirect_pc = '0;
    for (int k = 0; k < 4096; k++) mem[k] = 32'h10000000 + 32'(k);
    mem[8] = EBREAK;

    vecs.push_back(mk(1,0,0,0,      0,0,            -1,0,-1,-1));
    vecs.push_back(mk(1,0,0,0,      0,0,            0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      0,0,            0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      1,32'h10000000, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      1,32'h10000001, 'h4,0,1,0));
    vecs.push_back(mk(0,1,0,0,      0,0,            'h8,0,2,0));
    vecs.push_back(mk(0,1,0,0,      0,0,            'h8,0,2,0));
    vecs.push_back(mk(0,0,0,0,      1,32'h10000002, 'h8,0,2,0));
    vecs.push_back(mk(0,0,0,0,      1,32'h10000003, 'hC,0,3,0));
    vecs.push_back(mk(0,0,1,'h100,  0,0,            'h10,0,4,0));
    vecs.push_back(mk(0,0,0,0,      1,32'h10000040, 'h100,0,4,0));
    vecs.push_back(mk(0,1,1,'h203,  0,0,            'h104,0,5,0));
    vecs.push_back(mk(0,0,0,0,      1,32'h10000080, 'h200,0,5,1));
    vecs.push_back(mk(0,0,1,'h18,   0,0,            'h204,0,6,1));
    vecs.push_back(mk(0,0,0,0,      1,32'h10000006, 'h18,0,6,1));
    vecs.push_back(mk(0,0,0,0,      1,32'h10000007, 'h1C,0,7,1));
    vecs.push_back(mk(0,0,0,0,      1,EBREAK,       'h20,0,8,1));
    for (int k = 0; k < 5; k++)
      vecs.push_back(mk(0,0,0,0,    0,0,            'h24,1,9,1));
    vecs.push_back(mk(0,0,1,0,      0,0,            'h24,1,9,1));
    vecs.push_back(mk(0,0,0,0,      1,32'h10000000, 0,0,9,1));
    vecs.push_back(mk(0,0,1,'h3FF8, 0,0,            'h4,0,10,1));
    vecs.push_back(mk(0,0,0,0,      1,32'h10000FFE, 'h3FF8,0,10,1));
    vecs.push_back(mk(0,0,0,0,      1,32'h10000FFF, 'h3FFC,0,11,1));
    vecs.push_back(mk(0,0,0,0,      1,32'h10000000, 0,0,12,1));
    vecs.push_back(mk(1,1,1,'h123,  0,0,            'h4,0,13,1));
    vecs.push_back(mk(0,0,0,0,      0,0,            0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      1,32'h10000000, 0,0,0,0));
    vecs.push_back(mk(0,0,0,0,      1,32'h10000001, 'h4,0,1,0));

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].rst, vecs[i].stall, vecs[i].red, 14'(vecs[i].rpc));
      if (vecs[i].valid >= 0) begin
        check_output($sformatf("vec%0d_valid", i), {31'b0, valid_out}, 32'(vecs[i].valid));
        check_output($sformatf("vec%0d_instr", i), instruction_out,
                     vecs[i].valid == 1 ? vecs[i].instr : NOP);
      end
      if (vecs[i].pc >= 0)
        check_output($sformatf("vec%0d_pc", i), {18'b0, PC_out}, 32'(vecs[i].pc));
      if (vecs[i].halted >= 0)
        check_output($sformatf("vec%0d_halted", i), {31'b0, halted}, 32'(vecs[i].halted));
      if (vecs[i].count >= 0)
        check_output($sformatf("vec%0d_count", i), fetch_count, 32'(vecs[i].count));
      if (vecs[i].mis >= 0)
        check_output($sformatf("vec%0d_mis", i), {31'b0, misalign_err}, 32'(vecs[i].mis));
    end

    // Halt, then reset with a misaligned redirect pending: reset must win.
    apply_stimulus(0, 0, 1, 14'h1C);
    apply_stimulus(0, 0, 0, 14'h0);
    apply_stimulus(0, 0, 0, 14'h0);
    check_output("seq_ebreak_valid", {31'b0, valid_out}, 32'd1);
    apply_stimulus(0, 0, 0, 14'h0);
    check_output("seq_halted", {31'b0, halted}, 32'd1);
    apply_stimulus(1, 0, 1, 14'h103);
    check_output("seq_rst_halted", {31'b0, halted}, 32'd0);
    apply_stimulus(0, 0, 0, 14'h0);
    check_output("seq_boot_pc", {18'b0, PC_out}, 32'd0);
    check_output("seq_boot_mis", {31'b0, misalign_err}, 32'd0);
    check_output("seq_boot_valid", {31'b0, valid_out}, 32'd0);

    for (int n = 0; n < 400; n++) begin
      bit          r, s, rd;
      logic [13:0] rpc;
      r  = ($urandom_range(0, 99) < 2);
      s  = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 12);
      case ($urandom_range(0, 2))
        0:       rpc = 14'($urandom_range(0, 16383));
        1:       rpc = 14'('h18 + $urandom_range(0, 15));
        default: rpc = 14'('h3FF0 + $urandom_range(0, 15));
      endcase
      apply_stimulus(r, s, rd, rpc);
    end

    @(negedge clk);
    rst = 1'b0; stall = 1'b0; redirect_en = 1'b0;
    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
